// File: rtl/skew_feed_ctrl_pkg.sv
// rtl/skew_feed_ctrl_pkg.sv - shared types and constants for skew_feed_ctrl
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package skew_feed_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Zero-filled cycles needed to push the last vector through an N-wide skewer.
   localparam int DRAIN_LEN = `ARRAY_SIZE;

endpackage

// File: rtl/defines.sv
// rtl/defines.sv - default array geometry shared by the skew feed path
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// File: rtl/skew_feed_ctrl.sv
// rtl/skew_feed_ctrl.sv - streams K buffer vectors into the skewer, then drains it
module skew_feed_ctrl
   import skew_feed_ctrl_pkg::*;
#(
   parameter int N          = DRAIN_LEN,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [ADDR_WIDTH-1:0]              cfg_base,
   input  logic [LEN_WIDTH-1:0]               cfg_len,
   input  logic                               stall,
   output logic                               busy,
   output logic                               done,
   output logic                               rd_en,
   output logic [ADDR_WIDTH-1:0]              rd_addr,
   input  logic [N*DATA_WIDTH-1:0]            rd_data,
   output logic                               sk_en,
   output logic [N-1:0][DATA_WIDTH-1:0]       sk_data,
   output logic                               sk_first,
   output logic                               sk_last
);

   localparam int CW = $clog2(N + 1);

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [LEN_WIDTH-1:0]    issue_left;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [CW-1:0]           drain_cnt;

   // Read in flight: its data is on rd_data this cycle, tagged with its position.
   logic                    rd_pend;
   logic                    pend_first;
   logic                    pend_last;

   // Parked copy of a vector that arrived while the skewer was stalled.
   logic                    hv_q;
   logic                    hfirst_q;
   logic                    hlast_q;
   logic [N*DATA_WIDTH-1:0] hdata_q;

   // Effective hold contents: fresh read data bypasses the parked copy.
   logic                    hv;
   logic                    hfirst;
   logic                    hlast;
   logic [N*DATA_WIDTH-1:0] hdata;

   // Present either the returning read or the parked vector to the skewer.
   always_comb begin
      hv     = rd_pend | hv_q;
      hfirst = rd_pend ? pend_first : hfirst_q;
      hlast  = rd_pend ? pend_last  : hlast_q;
      hdata  = rd_pend ? rd_data    : hdata_q;
   end

   // State register; reset abandons any sequence without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and all outputs.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      sk_en    = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = addr;
      sk_data  = '0;
      sk_first = 1'b0;
      sk_last  = 1'b0;

      sk_en    = ((state == S_FEED) || (state == S_DRAIN)) && !stall;
      rd_en    = (state == S_FEED) && (issue_left != '0) && !stall;
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
      if (hv) begin
         sk_data  = hdata;
         sk_first = hfirst;
         sk_last  = hlast;
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (cfg_len == '0) ? S_DONE : S_FEED;
            end
         end
         S_FEED: begin
            if (sk_en && hv && hlast) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (sk_en && (drain_cnt <= CW'(1))) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Address and issue counters, plus first/last tags for the read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         issue_left <= '0;
         len_q      <= '0;
         rd_pend    <= 1'b0;
         pend_first <= 1'b0;
         pend_last  <= 1'b0;
      end else begin
         rd_pend <= rd_en;
         if ((state == S_IDLE) && start) begin
            addr       <= cfg_base;
            issue_left <= cfg_len;
            len_q      <= cfg_len;
         end else if (rd_en) begin
            addr       <= addr + ADDR_WIDTH'(1);
            issue_left <= issue_left - LEN_WIDTH'(1);
            pend_first <= (issue_left == len_q);
            pend_last  <= (issue_left == LEN_WIDTH'(1));
         end
      end
   end

   // Park returning data across a stall; release it once the skewer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hv_q     <= 1'b0;
         hfirst_q <= 1'b0;
         hlast_q  <= 1'b0;
         hdata_q  <= '0;
      end else if (rd_pend && stall) begin
         hv_q     <= 1'b1;
         hfirst_q <= pend_first;
         hlast_q  <= pend_last;
         hdata_q  <= rd_data;
      end else if (sk_en) begin
         hv_q     <= 1'b0;
         hfirst_q <= 1'b0;
         hlast_q  <= 1'b0;
      end
   end

   // Drain counter: armed by the last vector, counts down on each enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
      end else if ((state == S_FEED) && sk_en && hv && hlast) begin
         drain_cnt <= CW'(N);
      end else if ((state == S_DRAIN) && sk_en && (drain_cnt != '0)) begin
         drain_cnt <= drain_cnt - CW'(1);
      end
   end

endmodule
